// File: rtl/ftdi_reply_framer.sv
// ftdi_reply_framer: builds reply frames (sync, header, address, length, payload[, checksum]) into a write FIFO.
//   Parameters: SYNC_BYTE (first frame byte), HOLD_DEPTH (payload holding buffer depth, 2..4).
//   Inputs : clk, res_n (async active-low), req_valid/req_header/req_address/req_length (request),
//            data_valid/data_in (register-file read data), fifo_prog_full (backpressure).
//   Outputs: req_ready, fifo_wr_en/fifo_din (frame byte stream), busy, overflow, stray (sticky flags).
//   Optional: define FTDI_REPLY_CHECKSUM_EN to append an XOR checksum byte to every frame.
module ftdi_reply_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         HOLD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        req_valid,
  input  logic [7:0]  req_header,
  input  logic [7:0]  req_address,
  input  logic [15:0] req_length,
  output logic        req_ready,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        fifo_prog_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_din,
  output logic        busy,
  output logic        overflow,
  output logic        stray
);
  localparam int CW = $clog2(HOLD_DEPTH + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR, S_ADDR, S_LENH, S_LENL, S_PAYLOAD
`ifdef FTDI_REPLY_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;
`ifdef FTDI_REPLY_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_IDLE;
`endif
  state_t                      r_state, w_nxt;
  logic [7:0]                  r_hdr, r_addr, w_byte;
  logic [15:0]                 r_len, r_count;
  logic [HOLD_DEPTH-1:0][7:0]  r_hold, w_shift;
  logic [CW-1:0]               r_hcnt, w_wr_idx;
  logic                        w_pop, w_push, w_go;
`ifdef FTDI_REPLY_CHECKSUM_EN
  logic [7:0]                  r_csum;
`endif
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  // Holding buffer is a shift queue: entry 0 is always the next byte out.
  assign w_shift  = r_hold >> 8;
  assign w_pop    = (r_state == S_PAYLOAD) && (r_hcnt != '0) && !fifo_prog_full;
  assign w_push   = (r_state == S_PAYLOAD) && data_valid && ((r_hcnt != CW'(HOLD_DEPTH)) || w_pop);
  assign w_wr_idx = r_hcnt - CW'(w_pop);
  always_comb begin
    w_byte = SYNC_BYTE;
    w_nxt  = r_state;
    w_go   = 1'b0;
    case (r_state)
      S_SYNC:    begin w_byte = SYNC_BYTE;  w_nxt = S_HDR;  w_go = !fifo_prog_full; end
      S_HDR:     begin w_byte = r_hdr;      w_nxt = S_ADDR; w_go = !fifo_prog_full; end
      S_ADDR:    begin w_byte = r_addr;     w_nxt = S_LENH; w_go = !fifo_prog_full; end
      S_LENH:    begin w_byte = r_len[15:8]; w_nxt = S_LENL; w_go = !fifo_prog_full; end
      S_LENL:    begin w_byte = r_len[7:0];  w_nxt = (r_len == 16'd0) ? S_END : S_PAYLOAD; w_go = !fifo_prog_full; end
      S_PAYLOAD: begin w_byte = r_hold[0];   w_nxt = (r_count == 16'd1) ? S_END : S_PAYLOAD; w_go = w_pop; end
`ifdef FTDI_REPLY_CHECKSUM_EN
      S_CSUM:    begin w_byte = r_csum;      w_nxt = S_IDLE; w_go = !fifo_prog_full; end
`endif
      default:   ;
    endcase
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= S_IDLE;
      r_hdr      <= 8'h00;
      r_addr     <= 8'h00;
      r_len      <= 16'h0000;
      r_count    <= 16'h0000;
      r_hold     <= '0;
      r_hcnt     <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= 8'h00;
      overflow   <= 1'b0;
      stray      <= 1'b0;
`ifdef FTDI_REPLY_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      fifo_wr_en <= 1'b0;
      if (r_state == S_IDLE) begin
        if (req_valid) begin
          r_hdr    <= req_header;
          r_addr   <= req_address;
          r_len    <= req_length;
          r_count  <= req_length;
          overflow <= 1'b0;
          stray    <= 1'b0;
          r_state  <= S_SYNC;
`ifdef FTDI_REPLY_CHECKSUM_EN
          r_csum   <= 8'h00;
`endif
        end
      end else if (w_go) begin
        fifo_wr_en <= 1'b1;
        fifo_din   <= w_byte;
        r_state    <= w_nxt;
`ifdef FTDI_REPLY_CHECKSUM_EN
        r_csum     <= r_csum ^ w_byte;
`endif
      end
      if (w_pop) r_count <= r_count - 16'd1;
      for (int i = 0; i < HOLD_DEPTH; i++)
        if (w_push && (w_wr_idx == CW'(i))) r_hold[i] <= data_in;
        else if (w_pop) r_hold[i] <= w_shift[i];
      // Anything still held when the last payload byte leaves is surplus and discarded.
      r_hcnt <= (w_pop && (r_count == 16'd1)) ? '0 : r_hcnt + CW'(w_push) - CW'(w_pop);
      if (data_valid && (r_state != S_PAYLOAD)) stray <= 1'b1;
      if ((r_state == S_PAYLOAD) && data_valid && !w_push) overflow <= 1'b1;
    end
  end
endmodule
